i2c_cond_gen: RTL
=================

I2C_COND_GEN -- requirements
Module: i2c_cond_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, system clocks per SCL quarter-phase (legal range 2..65535).
REQ-002 SHALL have parameter DIV_W, default 16, width of the quarter-phase counter (DIV_W >= clog2(CLK_DIV)).
REQ-003 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd  input  2  command code: 00 NOP, 01 START, 10 RSTART (repeated start), 11 STOP.
REQ-007 SHALL have port cmd_ready  output  1  high when a command can be accepted.
REQ-008 SHALL have port scl_in  input  1  sampled SCL bus level.
REQ-009 SHALL have port sda_out  output  1  SDA drive (1 = release/high, 0 = pull low).
REQ-010 SHALL have port scl_out  output  1  SCL drive (1 = release/high, 0 = pull low).
REQ-011 SHALL have port done  output  1  one-cycle pulse when a sequence completes.
REQ-012 SHALL have port cmd_err  output  1  one-cycle pulse when an illegal command is rejected.
REQ-013 SHALL have port bus_owned  output  1  high from START completion until STOP completion.

Function
REQ-014 SHALL accept a command on a rising edge where cmd_valid and cmd_ready are both high; cmd_ready is high only in IDLE and HELD.
REQ-015 SHALL implement states IDLE, HELD, START, RSTART, STOP; the sub-phase index is 0..3 and each sub-phase lasts exactly CLK_DIV cycles.
REQ-016 SHALL enter the first sub-phase of the accepted sequence on the cycle after acceptance, so the output change appears one cycle after the accept edge.
REQ-017 START (legal only from IDLE) SHALL drive (sda,scl) = (1,1), (0,1), (0,0) for phases 0..2, then go to HELD with bus_owned=1.
REQ-018 RSTART (legal only from HELD) SHALL drive (1,0), (1,1), (0,1), (0,0) for phases 0..3, then return to HELD.
REQ-019 STOP (legal only from HELD) SHALL drive (0,0), (0,1), (1,1) for phases 0..2, then go to IDLE with bus_owned=0.
REQ-020 In HELD, outputs SHALL be (sda,scl) = (0,0); in IDLE they SHALL be (1,1).
REQ-021 done SHALL pulse in the cycle the FSM leaves the last sub-phase.
REQ-022 An illegal command (START in HELD; RSTART or STOP in IDLE) SHALL be accepted, SHALL pulse cmd_err in the following cycle, and SHALL cause no state or output change.
REQ-023 NOP SHALL be accepted with no effect and no pulse.
REQ-024 The quarter-phase counter SHALL count 0..CLK_DIV-1 and wrap to 0 when it advances the sub-phase; it SHALL never overflow DIV_W.
REQ-025 cmd_valid while the FSM is busy SHALL be ignored, and the command SHALL remain pending until cmd_ready is high.

Reset
REQ-026 When rst is high at a clock edge, the block SHALL go to IDLE with sda_out=1, scl_out=1, cmd_ready=1, done=0, cmd_err=0, bus_owned=0, and counter=0.
REQ-027 Reset asserted mid-sequence SHALL abort the sequence immediately (next edge) without generating a STOP and without pulsing done.

Configuration
REQ-028 Macro I2C_COND_STRETCH_EN SHALL enable clock-stretch support.
REQ-029 With I2C_COND_STRETCH_EN defined, the counter SHALL hold while scl_out=1 and scl_in=0, and sequences SHALL extend by the stretch duration.
REQ-030 Without I2C_COND_STRETCH_EN, scl_in SHALL be ignored and timing SHALL be fixed at CLK_DIV cycles per phase.

Verification (CLK_DIV=4)
REQ-031 Reset held, then START at cycle 10: cmd_ready falls at 11; sda=0 at 15; scl=0 at 19; done pulses at 22; bus_owned=1.
REQ-032 START, then STOP: STOP phases last 4 cycles each (12 cycles total); done pulses; final (1,1); bus_owned=0.
REQ-033 STOP issued in IDLE: cmd_err pulses 1 cycle after acceptance; outputs stay (1,1).
REQ-034 START, RSTART, STOP: exact phase sequence (1,0),(1,1),(0,1),(0,0) with 16 cycles total for the RSTART; two done pulses.
REQ-035 Reset at cycle 2 of START phase 1: next edge gives IDLE (1,1) with no done pulse.
REQ-036 With I2C_COND_STRETCH_EN: scl_in held low for 10 cycles during STOP phase 1 extends STOP by 10 cycles; without the macro, the STOP length is unchanged.

Source files
------------

// File: rtl/i2c_cond_gen_if.sv
// Command/bus bundle for the I2C START / repeated-START / STOP condition generator.
// master drives commands and the sampled SCL level; slave is the generator itself.
interface i2c_cond_gen_if;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       cmd_ready;
    logic       scl_in;
    logic       sda_out;
    logic       scl_out;
    logic       done;
    logic       cmd_err;
    logic       bus_owned;

    modport master (
        output cmd_valid, cmd, scl_in,
        input  cmd_ready, sda_out, scl_out, done, cmd_err, bus_owned
    );

    modport slave (
        input  cmd_valid, cmd, scl_in,
        output cmd_ready, sda_out, scl_out, done, cmd_err, bus_owned
    );
endinterface

// File: rtl/i2c_cond_gen.sv
// I2C bus condition generator: START, repeated START and STOP, each a sequence of CLK_DIV-cycle quarter-phases.
// Define I2C_COND_STRETCH_EN to hold the phase counter while a slave stretches SCL low.
module i2c_cond_gen #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned DIV_W   = 16
) (
    input  logic           clk,
    input  logic           rst,
    i2c_cond_gen_if.slave  bus
);

    typedef enum logic [2:0] {S_IDLE, S_HELD, S_START, S_RSTART, S_STOP} state_e;
    typedef enum logic [1:0] {C_NOP, C_START, C_RSTART, C_STOP} cmd_e;

    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(CLK_DIV - 1);

    state_e           state;
    logic [1:0]       phase;
    logic [DIV_W-1:0] cnt;
    logic             sda_q;
    logic             scl_q;
    logic             ready_q;
    logic             err_q;
    logic             owned_q;
    logic             busy;
    logic             stall;
    logic             phase_end;
    logic             last_phase;

    // (sda, scl) levels for each sub-phase of a sequence
    function automatic logic [1:0] drive(state_e s, logic [1:0] p);
        logic [1:0] v;
        v = 2'b11;
        case (s)
            S_START:  v = (p == 2'd0) ? 2'b11 : (p == 2'd1) ? 2'b01 : 2'b00;
            S_RSTART: v = (p == 2'd0) ? 2'b10 : (p == 2'd1) ? 2'b11 :
                          (p == 2'd2) ? 2'b01 : 2'b00;
            S_STOP:   v = (p == 2'd0) ? 2'b00 : (p == 2'd1) ? 2'b01 : 2'b11;
            S_HELD:   v = 2'b00;
            default:  v = 2'b11;
        endcase
        return v;
    endfunction

    function automatic logic [1:0] final_phase(state_e s);
        return (s == S_RSTART) ? 2'd3 : 2'd2;
    endfunction

`ifdef I2C_COND_STRETCH_EN
    // A slave holding SCL low while we release it freezes the quarter-phase timer
    assign stall = busy && scl_q && !bus.scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = bus.scl_in;
    assign stall         = 1'b0;
`endif

    assign busy       = (state == S_START) || (state == S_RSTART) || (state == S_STOP);
    assign phase_end  = busy && !stall && (cnt == CNT_LAST);
    assign last_phase = (phase == final_phase(state));

    // done is decoded from registered state so it sits in the exact cycle the sequence ends
    assign bus.done      = phase_end && last_phase;
    assign bus.sda_out   = sda_q;
    assign bus.scl_out   = scl_q;
    assign bus.cmd_ready = ready_q;
    assign bus.cmd_err   = err_q;
    assign bus.bus_owned = owned_q;

    // NOTE: all state here is updated with non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            phase   <= 2'd0;
            cnt     <= '0;
            sda_q   <= 1'b1;
            scl_q   <= 1'b1;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
            owned_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (bus.cmd_valid && ready_q) begin
                phase <= 2'd0;
                cnt   <= '0;
                case (cmd_e'(bus.cmd))
                    C_START: begin
                        if (state == S_IDLE) begin
                            state          <= S_START;
                            {sda_q, scl_q} <= drive(S_START, 2'd0);
                            ready_q        <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    C_RSTART: begin
                        if (state == S_HELD) begin
                            state          <= S_RSTART;
                            {sda_q, scl_q} <= drive(S_RSTART, 2'd0);
                            ready_q        <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    C_STOP: begin
                        if (state == S_HELD) begin
                            state          <= S_STOP;
                            {sda_q, scl_q} <= drive(S_STOP, 2'd0);
                            ready_q        <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else if (busy) begin
                if (phase_end) begin
                    cnt <= '0;
                    if (last_phase) begin
                        state          <= (state == S_STOP) ? S_IDLE : S_HELD;
                        {sda_q, scl_q} <= (state == S_STOP) ? 2'b11 : 2'b00;
                        owned_q        <= (state != S_STOP);
                        ready_q        <= 1'b1;
                        phase          <= 2'd0;
                    end else begin
                        phase          <= phase + 2'd1;
                        {sda_q, scl_q} <= drive(state, phase + 2'd1);
                    end
                end else if (!stall) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule
